imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Instruction-memory writer (program loader) for the Y86-64 sequential core.
- Accepts one decoded instruction per handshake as icode/ifun/rA/rB/valC and serializes it into the byte-addressed instruction memory.
- Uses exactly the byte layout the fetch stage decodes.
- Writes one byte per cycle at an internal write pointer, then advances the pointer by the instruction length.

Parameters:
MEM_SIZE, 2048, instruction memory size in bytes; valid addresses are 0..MEM_SIZE-1
START_ADDR, 0, write-pointer value after reset

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  asynchronous, active-high reset
org_valid  in  1  load write pointer from org_addr (honoured only in IDLE)
org_addr  in  64  new write-pointer value
in_valid  in  1  instruction fields valid
in_ready  out  1  loader can accept an instruction
icode  in  4  instruction code
ifun  in  4  function code
rA  in  4  register A specifier
rB  in  4  register B specifier
valC  in  64  constant / destination
wr_en  out  1  byte write strobe to instruction memory
wr_addr  out  64  byte address
wr_data  out  8  byte value
next_pc  out  64  write pointer (address of next instruction)
inst_err  out  1  one-cycle pulse: rejected invalid icode
imem_er  out  1  sticky: instruction would exceed MEM_SIZE
busy  out  1  emitting bytes

Behaviour:
- Reset: state IDLE; next_pc=START_ADDR; wr_en=0; wr_addr=0; wr_data=0; inst_err=0; imem_er=0; busy=0.
- Reset mid-emission aborts immediately. No further writes. Bytes already written are left in memory.
- Instruction length (len) by icode:
  - 0 halt, 1 nop, 9 ret: len 1
  - 2 cmovXX, 6 OPq, 10 pushq, 11 popq: len 2
  - 3 irmovq, 4 rmmovq, 5 mrmovq: len 10
  - 7 jXX, 8 call: len 9
  - 12..15: invalid
- Byte image:
  - Byte0 = {icode,ifun}.
  - Len-2 and len-10 instructions: byte1 = {rA,rB}.
  - Len 10: bytes2..9 = valC, MSB first (byte2 = valC[63:56], byte9 = valC[7:0]).
  - Len 9: bytes1..8 = valC, MSB first; rA/rB ignored.
  - Fields are written verbatim; no register-specifier checking.
- States: IDLE, EMIT, ERR.
- IDLE:
  - in_ready=1, busy=0.
  - org_valid loads next_pc=org_addr. If org_valid and in_valid are high in the same cycle, org takes priority and the instruction is not accepted (in_ready=0 that cycle).
  - Accept when in_valid&&in_ready: latch fields and compute len.
    - Invalid icode: inst_err=1 for the next cycle only, no writes, next_pc unchanged, stay IDLE.
    - next_pc+len > MEM_SIZE (computed 65-bit, no wrap): imem_er<=1, go ERR, no writes.
    - Otherwise go EMIT with byte index k=0.
- EMIT:
  - in_ready=0, busy=1, wr_en=1 (registered outputs).
  - wr_addr=next_pc+k, wr_data=byte k; k increments each cycle.
  - Written on the same cycle as byte len-1: next_pc<=next_pc+len, state<=IDLE.
  - org_valid ignored.
- Timing: accept on edge N gives writes on cycles N+1..N+len and in_ready high again in cycle N+len+1. Throughput is one instruction per len+1 cycles.
- ERR: in_ready=0, wr_en=0, imem_er=1; exited only by rst.

Optional Feature:
- Macro: LOADER_HALT_LOCK_EN.
- Defined:
  - After the last byte of a halt (icode 0) is written, the loader enters a HALTED state: in_ready=0, org_valid ignored, until rst.
  - next_pc points past the halt byte.
- Undefined: halt is written like any len-1 instruction and loading continues.

Test Plan:
- irmovq $4,%rax (icode3 ifun0 rA=F rB=0 valC=4) at 0 -> addr0..9 = 0x30,0xF0,0x00×7,0x04; next_pc=10; wr_en high exactly 10 cycles.
- Then irmovq $10,%rbx (rB=3) and addq %rax,%rbx (icode6 rA0 rB3) -> addr10..19 = 0x30,0xF3,0×7,0x0A; addr20=0x60, addr21=0x03; next_pc=22.
- jmp (icode7 ifun0 valC=0x0102030405060708) at 100 -> addr100..108 = 0x70,0x01..0x08; next_pc=109.
- icode=12 offered -> inst_err one-cycle pulse, no wr_en, next_pc unchanged; next valid nop writes 0x10 at the same address.
- org to 2040, irmovq -> imem_er=1, no writes, in_ready stays 0 until rst; after rst next_pc=0, imem_er=0.
- rst asserted during 4th byte of an irmovq -> wr_en drops asynchronously, next_pc=START_ADDR. With LOADER_HALT_LOCK_EN: halt at 5 -> addr5=0x00, next_pc=6, in_ready held 0.

Source files
------------

// File: rtl/imem_loader_if.sv
// imem_loader_if: instruction handshake and origin-load bus between program source and imem_loader
interface imem_loader_if;
  logic org_valid;
  logic [63:0] org_addr;
  logic in_valid;
  logic in_ready;
  logic [3:0] icode;
  logic [3:0] ifun;
  logic [3:0] rA;
  logic [3:0] rB;
  logic [63:0] valC;
  modport master(output org_valid, org_addr, in_valid, icode, ifun, rA, rB, valC, input in_ready);
  modport slave(input org_valid, org_addr, in_valid, icode, ifun, rA, rB, valC, output in_ready);
endinterface

// File: rtl/imem_loader.sv
// imem_loader: Y86-64 program loader serializing decoded instructions into byte memory; LOADER_HALT_LOCK_EN locks after halt
module imem_loader #(
  parameter int MEM_SIZE = 2048,
  parameter logic [63:0] START_ADDR = 64'd0
) (
  input  logic clk,
  input  logic rst,
  imem_loader_if.slave bus,
  output logic wr_en,
  output logic [63:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [63:0] next_pc,
  output logic inst_err,
  output logic imem_er,
  output logic busy
);
`ifdef LOADER_HALT_LOCK_EN
  localparam bit HALT_LOCK = 1'b1;
`else
  localparam bit HALT_LOCK = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, EMIT, ERR, HALTED} state_t;
  state_t state, state_n;
  logic [3:0] len, rem;
  logic [79:0] img;
  logic [71:0] sh;
  logic accept, bad, ovf, done, is_halt;
  assign len = (bus.icode == 4'd0 || bus.icode == 4'd1 || bus.icode == 4'd9) ? 4'd1 :
               (bus.icode == 4'd2 || bus.icode == 4'd6 || bus.icode == 4'd10 || bus.icode == 4'd11) ? 4'd2 :
               (bus.icode >= 4'd3 && bus.icode <= 4'd5) ? 4'd10 :
               (bus.icode == 4'd7 || bus.icode == 4'd8) ? 4'd9 : 4'd0;
  assign bad = len == 4'd0;
  assign ovf = ({1'b0, next_pc} + 65'(len)) > 65'(MEM_SIZE);
  assign img = (len == 4'd9) ? {bus.icode, bus.ifun, bus.valC, 8'h00}
                             : {bus.icode, bus.ifun, bus.rA, bus.rB, bus.valC};
  assign bus.in_ready = state == IDLE && !bus.org_valid;
  assign accept = bus.in_valid && bus.in_ready;
  assign done = rem == 4'd0;
  assign busy = state == EMIT;
  always_comb
    state_n = (state == IDLE && accept && !bad) ? (ovf ? ERR : EMIT) :
              (state == EMIT && done) ? ((HALT_LOCK && is_halt) ? HALTED : IDLE) : state;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      next_pc <= START_ADDR;
      wr_en <= 1'b0;
      wr_addr <= 64'd0;
      wr_data <= 8'd0;
      inst_err <= 1'b0;
      imem_er <= 1'b0;
      sh <= 72'd0;
      rem <= 4'd0;
      is_halt <= 1'b0;
    end else begin
      inst_err <= accept && bad;
      if (state == IDLE && bus.org_valid) next_pc <= bus.org_addr;
      if (accept && !bad && ovf) imem_er <= 1'b1;
      if (accept && !bad && !ovf) begin
        wr_en <= 1'b1;
        wr_addr <= next_pc;
        wr_data <= img[79:72];
        sh <= img[71:0];
        rem <= len - 4'd1;
        is_halt <= bus.icode == 4'd0;
      end
      if (state == EMIT) begin
        wr_en <= !done;
        if (done) next_pc <= wr_addr + 64'd1;
        else begin
          wr_addr <= wr_addr + 64'd1;
          wr_data <= sh[71:64];
          sh <= {sh[63:0], 8'h00};
          rem <= rem - 4'd1;
        end
      end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized and directed bench for imem_loader against a byte-queue reference model
module tb_imem_loader;
  localparam int MS = 2048;
`ifdef LOADER_HALT_LOCK_EN
  localparam bit HL = 1'b1;
`else
  localparam bit HL = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  imem_loader_if bus();
  logic wr_en, inst_err, imem_er, busy;
  logic [63:0] wr_addr, next_pc;
  logic [7:0] wr_data;
  imem_loader #(.MEM_SIZE(MS), .START_ADDR(64'd0)) dut (
    .clk(clk), .rst(rst), .bus(bus), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .next_pc(next_pc), .inst_err(inst_err), .imem_er(imem_er), .busy(busy)
  );
  int checks = 0;
  int failures = 0;
  int wcount = 0;
  logic [7:0] mem [0:MS-1];
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", n, a, e, $time);
    end
  endtask
  typedef struct {
    logic [63:0] a;
    logic [7:0] d;
  } wb_t;
  wb_t q[$];
  int lt [16] = '{1, 1, 2, 10, 10, 10, 2, 9, 9, 1, 2, 2, 0, 0, 0, 0};
  logic [63:0] m_pc = 64'd0;
  logic [63:0] pend_pc = 64'd0;
  bit m_err, m_ierr, m_halt, pend_halt;
  int ml, off;
  logic [64:0] mend;
  logic [7:0] mb [10];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_pc = 64'd0;
      m_err = 0;
      m_ierr = 0;
      m_halt = 0;
    end else begin
      m_ierr = 0;
      if (q.size() > 0) begin
        void'(q.pop_front());
        if (q.size() == 0) begin
          m_pc = pend_pc;
          m_halt = pend_halt;
        end
      end else if (!m_err && !m_halt) begin
        if (bus.org_valid) m_pc = bus.org_addr;
        else if (bus.in_valid) begin
          ml = lt[bus.icode];
          mend = {1'b0, m_pc} + 65'(ml);
          if (ml == 0) m_ierr = 1;
          else if (mend > 65'(MS)) m_err = 1;
          else begin
            mb[0] = {bus.icode, bus.ifun};
            mb[1] = {bus.rA, bus.rB};
            off = (ml == 9) ? 1 : 2;
            for (int i = 0; i < 8; i++) mb[off + i] = bus.valC[63 - 8 * i -: 8];
            for (int i = 0; i < ml; i++) q.push_back(wb_t'{m_pc + 64'(i), mb[i]});
            pend_pc = mend[63:0];
            pend_halt = HL && bus.icode == 4'd0;
          end
        end
      end
    end
  end
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      chk("wr_en", 64'(wr_en), 64'(q.size() > 0));
      if (q.size() > 0) begin
        chk("wr_addr", wr_addr, q[0].a);
        chk("wr_data", 64'(wr_data), 64'(q[0].d));
      end
      if (wr_en === 1'b1 && wr_addr < 64'(MS)) begin
        mem[wr_addr[10:0]] = wr_data;
        wcount++;
      end
      chk("busy", 64'(busy), 64'(q.size() > 0));
      chk("in_ready", 64'(bus.in_ready), 64'(q.size() == 0 && !m_err && !m_halt && !bus.org_valid));
      chk("next_pc", next_pc, m_pc);
      chk("inst_err", 64'(inst_err), 64'(m_ierr));
      chk("imem_er", 64'(imem_er), 64'(m_err));
    end
  end
  task automatic send(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                      input logic [3:0] rb, input logic [63:0] vc);
    int t;
    @(negedge clk);
    bus.icode = ic;
    bus.ifun = fn;
    bus.rA = ra;
    bus.rB = rb;
    bus.valC = vc;
    bus.in_valid = 1'b1;
    #1;
    t = 0;
    while (!bus.in_ready && t < 40) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (t == 40) begin
      checks++;
      failures++;
      $display("FAIL accept_wait in_ready got=0 exp=1");
    end
    @(posedge clk);
    #2;
    bus.in_valid = 1'b0;
  endtask
  task automatic drain();
    int t;
    t = 0;
    while (busy && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (t == 40) begin
      checks++;
      failures++;
      $display("FAIL drain_wait busy got=1 exp=0");
    end
    @(negedge clk);
  endtask
  task automatic org(input logic [63:0] a);
    @(negedge clk);
    bus.org_valid = 1'b1;
    bus.org_addr = a;
    @(negedge clk);
    bus.org_valid = 1'b0;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic clear_mem();
    for (int i = 0; i < MS; i++) mem[i] = 8'hEE;
    wcount = 0;
  endtask
  initial begin
    bus.org_valid = 1'b0;
    bus.org_addr = 64'd0;
    bus.in_valid = 1'b0;
    bus.icode = 4'd0;
    bus.ifun = 4'd0;
    bus.rA = 4'd0;
    bus.rB = 4'd0;
    bus.valC = 64'd0;
    clear_mem();
    repeat (2) @(negedge clk);
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_wr_addr", wr_addr, 64'd0);
    chk("rst_wr_data", 64'(wr_data), 64'd0);
    chk("rst_next_pc", next_pc, 64'd0);
    chk("rst_inst_err", 64'(inst_err), 64'd0);
    chk("rst_imem_er", 64'(imem_er), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    send(4'h3, 4'h0, 4'hF, 4'h0, 64'd4);
    drain();
    chk("irm1_b0", 64'(mem[0]), 64'h30);
    chk("irm1_b1", 64'(mem[1]), 64'hF0);
    chk("irm1_b2", 64'(mem[2]), 64'h00);
    chk("irm1_b8", 64'(mem[8]), 64'h00);
    chk("irm1_b9", 64'(mem[9]), 64'h04);
    chk("irm1_pc", next_pc, 64'd10);
    chk("irm1_cnt", 64'(wcount), 64'd10);
    send(4'h3, 4'h0, 4'hF, 4'h3, 64'd10);
    send(4'h6, 4'h0, 4'h0, 4'h3, 64'd0);
    drain();
    chk("irm2_b10", 64'(mem[10]), 64'h30);
    chk("irm2_b11", 64'(mem[11]), 64'hF3);
    chk("irm2_b19", 64'(mem[19]), 64'h0A);
    chk("addq_b20", 64'(mem[20]), 64'h60);
    chk("addq_b21", 64'(mem[21]), 64'h03);
    chk("addq_pc", next_pc, 64'd22);
    org(64'd100);
    send(4'h7, 4'h0, 4'h5, 4'h5, 64'h0102030405060708);
    drain();
    chk("jmp_b100", 64'(mem[100]), 64'h70);
    chk("jmp_b101", 64'(mem[101]), 64'h01);
    chk("jmp_b108", 64'(mem[108]), 64'h08);
    chk("jmp_pc", next_pc, 64'd109);
    clear_mem();
    send(4'hC, 4'h0, 4'h0, 4'h0, 64'd0);
    chk("inv_pulse", 64'(inst_err), 64'd1);
    @(posedge clk);
    #2;
    chk("inv_clear", 64'(inst_err), 64'd0);
    chk("inv_nowr", 64'(wcount), 64'd0);
    chk("inv_pc", next_pc, 64'd109);
    send(4'h1, 4'h0, 4'h0, 4'h0, 64'd0);
    drain();
    chk("nop_b109", 64'(mem[109]), 64'h10);
    chk("nop_pc", next_pc, 64'd110);
    clear_mem();
    org(64'd2040);
    send(4'h3, 4'h0, 4'hF, 4'h0, 64'd4);
    @(negedge clk);
    chk("ovf_er", 64'(imem_er), 64'd1);
    chk("ovf_rdy", 64'(bus.in_ready), 64'd0);
    bus.in_valid = 1'b1;
    repeat (5) @(negedge clk);
    bus.in_valid = 1'b0;
    chk("ovf_rdy_hold", 64'(bus.in_ready), 64'd0);
    chk("ovf_nowr", 64'(wcount), 64'd0);
    do_reset();
    chk("ovf_rst_pc", next_pc, 64'd0);
    chk("ovf_rst_er", 64'(imem_er), 64'd0);
    send(4'h3, 4'h0, 4'hF, 4'h0, 64'h1122334455667788);
    repeat (3) @(posedge clk);
    #2;
    chk("abort_addr", wr_addr, 64'd3);
    chk("abort_data", 64'(wr_data), 64'h22);
    #1 rst = 1'b1;
    #1;
    chk("abort_wr_en", 64'(wr_en), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_pc", next_pc, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    clear_mem();
    org(64'd5);
    send(4'h0, 4'h0, 4'h0, 4'h0, 64'd0);
    drain();
    chk("halt_b5", 64'(mem[5]), 64'h00);
    chk("halt_pc", next_pc, 64'd6);
    if (HL) begin
      bus.icode = 4'h1;
      bus.in_valid = 1'b1;
      bus.org_valid = 1'b1;
      bus.org_addr = 64'd50;
      repeat (4) @(negedge clk);
      chk("halt_lock_rdy", 64'(bus.in_ready), 64'd0);
      chk("halt_lock_pc", next_pc, 64'd6);
      bus.in_valid = 1'b0;
      bus.org_valid = 1'b0;
      do_reset();
    end else begin
      send(4'h1, 4'h0, 4'h0, 4'h0, 64'd0);
      drain();
      chk("halt_cont_b6", 64'(mem[6]), 64'h10);
      chk("halt_cont_pc", next_pc, 64'd7);
    end
    repeat (3000) begin
      @(negedge clk);
      if (m_err || m_halt || $urandom_range(0, 399) == 0) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      bus.org_valid = $urandom_range(0, 15) == 0;
      bus.org_addr = ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFF8 + 64'($urandom_range(0, 7))
                                                 : 64'($urandom_range(0, MS + 8));
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.icode = 4'($urandom_range(0, 15));
      bus.ifun = 4'($urandom_range(0, 15));
      bus.rA = 4'($urandom_range(0, 15));
      bus.rB = 4'($urandom_range(0, 15));
      bus.valC = {$urandom(), $urandom()};
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.org_valid = 1'b0;
    repeat (12) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
